multi_latch_sampler: RTL

MULTI_LATCH_SAMPLER -- requirements
Module: multi_latch_sampler

---
 rtl/multi_latch_sampler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multi_latch_sampler.sv
// Multi-sample comparator latch sequencer: synchronises CH pad pairs and runs a
// PRE/EVAL cycle VOTES times. Each channel then takes a majority decision, or is flagged undecided.
//
// state | meaning
// IDLE  | waiting for ena & start
// PRE   | latch precharge, one cycle
// EVAL  | latch evaluate, one vote taken per channel
// DONE  | decision published, valid pulse
module multi_latch_sampler #(
    parameter int CH    = 4,
    parameter int VOTES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic          cont,
    input  logic [CH-1:0] vip,
    input  logic [CH-1:0] vin,
    output logic          strobe,
    output logic          busy,
    output logic          valid,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] undec
);

    localparam int CW = $clog2(VOTES + 1);
    localparam logic [CW-1:0] VMAX = CW'(VOTES);
    localparam logic [CW-1:0] HALF = CW'(VOTES / 2);

    typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

    state_t state, state_nxt;

    logic [CH-1:0] vip_s1, vip_s2, vin_s1, vin_s2;
    logic [CH-1:0][CW-1:0] ones, zeros, ones_inc, zeros_inc;
    logic [CW-1:0] samp, samp_inc;
    logic clr, count, decide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vip_s1 <= '0;
            vip_s2 <= '0;
            vin_s1 <= '0;
            vin_s2 <= '0;
        end else begin
            vip_s1 <= vip;
            vip_s2 <= vip_s1;
            vin_s1 <= vin;
            vin_s2 <= vin_s1;
        end
    end

    // Saturating vote counters; equal pairs (metastable sample) leave both unchanged.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            ones_inc[i]  = ones[i];
            zeros_inc[i] = zeros[i];
            if (vip_s2[i] && !vin_s2[i] && ones[i] != VMAX)
                ones_inc[i] = ones[i] + CW'(1);
            if (!vip_s2[i] && vin_s2[i] && zeros[i] != VMAX)
                zeros_inc[i] = zeros[i] + CW'(1);
        end
        samp_inc = (samp != VMAX) ? samp + CW'(1) : samp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        count     = 1'b0;
        decide    = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
            clr       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = PRE;
                        clr       = 1'b1;
                    end
                end
                PRE: state_nxt = EVAL;
                EVAL: begin
                    count = 1'b1;
                    if (samp_inc < VMAX) begin
                        state_nxt = PRE;
                    end else begin
                        state_nxt = DONE;
                        decide    = 1'b1;
                    end
                end
                DONE: begin
                    clr = 1'b1;
                    if (cont)
                        state_nxt = PRE;
                    else
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones  <= '0;
            zeros <= '0;
            samp  <= '0;
        end else if (clr) begin
            ones  <= '0;
            zeros <= '0;
            samp  <= '0;
        end else if (count) begin
            ones  <= ones_inc;
            zeros <= zeros_inc;
            samp  <= samp_inc;
        end
    end

    // The decision includes the vote taken on the final EVAL edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            undec <= '1;
        end else if (decide) begin
            for (int i = 0; i < CH; i++) begin
                dout[i]  <= (ones_inc[i] > HALF);
                undec[i] <= (ones_inc[i] <= HALF) && (zeros_inc[i] <= HALF);
            end
        end
    end

    // Status outputs are flops loaded from the next state, so they track state without decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            strobe <= (state_nxt == EVAL);
            busy   <= (state_nxt == PRE) || (state_nxt == EVAL);
            valid  <= (state_nxt == DONE);
        end
    end

endmodule
